unidade_controle_multiciclo: RTL and testbench

Multi-cycle control unit for the MIPS-style datapath: a Moore state machine sequencing fetch, decode, execute, memory, write-back and I/O-wait steps per instruction. It replaces single-cycle opcode decoding and adds three things:
- variable-latency multiply/divide;
- a ready/valid handshake for `in`/`out`;
- a sticky halt state.

It sits between the instruction register and the datapath muxes and write enables, and also drives PC and IR loading.

---
 rtl/controle_pkg.sv | 74 +++++++
 rtl/unidade_controle_multiciclo_if.sv | 42 ++++
 rtl/decodificador_campos.sv | 62 ++++++
 rtl/unidade_controle_multiciclo.sv | 157 +++++++++++++++
 tb/tb_unidade_controle_multiciclo.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/controle_pkg.sv
// Shared definitions for the multi-cycle control unit: opcode map, ALU
// operation codes, FSM state encoding and opcode classification helpers.
package controle_pkg;

    // Opcode map shared with the datapath (low five bits of the opcode).
    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_MUL    = 5'd2;
    localparam logic [4:0] OP_DIV    = 5'd3;
    localparam logic [4:0] OP_ADDI   = 5'd4;
    localparam logic [4:0] OP_SUBI   = 5'd5;
    localparam logic [4:0] OP_OR     = 5'd6;
    localparam logic [4:0] OP_NOT    = 5'd7;
    localparam logic [4:0] OP_AND    = 5'd8;
    localparam logic [4:0] OP_LW     = 5'd9;
    localparam logic [4:0] OP_SW     = 5'd10;
    localparam logic [4:0] OP_LOADI  = 5'd11;
    localparam logic [4:0] OP_MOVE   = 5'd12;
    localparam logic [4:0] OP_NOP    = 5'd13;
    localparam logic [4:0] OP_HLT    = 5'd14;
    localparam logic [4:0] OP_IN     = 5'd15;
    localparam logic [4:0] OP_OUT    = 5'd16;
    localparam logic [4:0] OP_JR     = 5'd17;
    localparam logic [4:0] OP_JAL    = 5'd18;
    localparam logic [4:0] OP_JUMP   = 5'd19;
    localparam logic [4:0] OP_SLT    = 5'd20;
    localparam logic [4:0] OP_BEQ    = 5'd21;
    localparam logic [4:0] OP_BGT    = 5'd22;
    localparam logic [4:0] OP_BLET   = 5'd23;
    localparam logic [4:0] OP_LOADR  = 5'd24;
    localparam logic [4:0] OP_STOREI = 5'd25;
    localparam logic [4:0] OP_STORER = 5'd26;

    // ALU operation codes driven on OpALU.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_MUL  = 4'b0010;
    localparam logic [3:0] ALU_DIV  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_NOT  = 4'b0110;
    localparam logic [3:0] ALU_BEQ  = 4'b0111;
    localparam logic [3:0] ALU_BGT  = 4'b1000;
    localparam logic [3:0] ALU_BLET = 4'b1001;
    localparam logic [3:0] ALU_SLT  = 4'b1010;
    localparam logic [3:0] ALU_JAL  = 4'b1011;

    typedef enum logic [2:0] {
        INICIO,
        BUSCA,
        DECODIFICA,
        EXECUTA,
        MEMORIA,
        ESPERA_IO,
        ESCRITA,
        PARADO
    } estado_t;

    // Instructions that read memory and write the result to a register.
    function automatic logic eh_load(input logic [4:0] op);
        return (op == OP_LW) || (op == OP_LOADI) || (op == OP_LOADR);
    endfunction

    // Instructions that write memory and retire without a register write.
    function automatic logic eh_store(input logic [4:0] op);
        return (op == OP_SW) || (op == OP_STOREI) || (op == OP_STORER);
    endfunction

    // Conditional branches.
    function automatic logic eh_desvio(input logic [4:0] op);
        return (op == OP_BEQ) || (op == OP_BGT) || (op == OP_BLET);
    endfunction

endpackage

// File: rtl/unidade_controle_multiciclo_if.sv
// Control bus between the control unit and the datapath / I/O handshake.
// master = control unit, slave = datapath side.
interface unidade_controle_multiciclo_if #(
    parameter int OPCODE_W = 6,
    parameter int OPALU_W  = 4
);
    logic [OPCODE_W-1:0] OPCODE;
    logic                entrada_valida;
    logic                saida_pronta;

    logic                EscrevePC;
    logic                EscreveIR;
    logic                RegDst;
    logic                Memtoreg;
    logic [1:0]          OrigALU;
    logic [1:0]          selExtensor;
    logic [OPALU_W-1:0]  OpALU;
    logic                Branch;
    logic                Jump;
    logic                Jr;
    logic                EscreveMem;
    logic                EscreveReg;
    logic                Enable;
    logic                in;
    logic                out;
    logic                hlt;
    logic                opcode_invalido;

    modport master (
        input  OPCODE, entrada_valida, saida_pronta,
        output EscrevePC, EscreveIR, RegDst, Memtoreg, OrigALU, selExtensor,
               OpALU, Branch, Jump, Jr, EscreveMem, EscreveReg, Enable,
               in, out, hlt, opcode_invalido
    );

    modport slave (
        output OPCODE, entrada_valida, saida_pronta,
        input  EscrevePC, EscreveIR, RegDst, Memtoreg, OrigALU, selExtensor,
               OpALU, Branch, Jump, Jr, EscreveMem, EscreveReg, Enable,
               in, out, hlt, opcode_invalido
    );
endinterface

// File: rtl/decodificador_campos.sv
// Purely combinational opcode decoder: static datapath fields plus a
// validity flag. Unused fields of an instruction drive 0.
module decodificador_campos import controle_pkg::*; #(
    parameter int OPCODE_W = 6,
    parameter int OPALU_W  = 4
) (
    input  logic [OPCODE_W-1:0] opcode,
    output logic                reg_dst,
    output logic                memtoreg,
    output logic [1:0]          orig_alu,
    output logic [1:0]          sel_extensor,
    output logic [OPALU_W-1:0]  op_alu,
    output logic                enable,
    output logic                valido
);

    logic [4:0] op;

    assign op = opcode[4:0];

    // Any opcode with a non-zero upper part, or above storeR, is undefined.
    assign valido = ((opcode >> 5) == '0) && (op <= OP_STORER);

    // Field table. OrigALU: 00 register, 01 immediate, 10 return address,
    // 11 constant zero. selExtensor: 00 sign-extend, 01 zero-extend, 10 jump target.
    always_comb begin
        reg_dst      = 1'b0;
        memtoreg     = 1'b0;
        orig_alu     = 2'b00;
        sel_extensor = 2'b00;
        op_alu       = '0;
        enable       = 1'b0;
        if (valido) begin
            case (op)
                OP_ADD:    begin reg_dst = 1'b1; op_alu = OPALU_W'(ALU_ADD); end
                OP_SUB:    begin reg_dst = 1'b1; op_alu = OPALU_W'(ALU_SUB); end
                OP_MUL:    begin reg_dst = 1'b1; op_alu = OPALU_W'(ALU_MUL); enable = 1'b1; end
                OP_DIV:    begin reg_dst = 1'b1; op_alu = OPALU_W'(ALU_DIV); enable = 1'b1; end
                OP_ADDI:   begin orig_alu = 2'b01; op_alu = OPALU_W'(ALU_ADD); end
                OP_SUBI:   begin orig_alu = 2'b01; op_alu = OPALU_W'(ALU_SUB); end
                OP_OR:     begin reg_dst = 1'b1; op_alu = OPALU_W'(ALU_OR); end
                OP_NOT:    begin reg_dst = 1'b1; op_alu = OPALU_W'(ALU_NOT); end
                OP_AND:    begin reg_dst = 1'b1; op_alu = OPALU_W'(ALU_AND); end
                OP_LW:     begin memtoreg = 1'b1; orig_alu = 2'b01; op_alu = OPALU_W'(ALU_ADD); end
                OP_SW:     begin orig_alu = 2'b01; op_alu = OPALU_W'(ALU_ADD); end
                OP_LOADI:  begin memtoreg = 1'b1; orig_alu = 2'b01; sel_extensor = 2'b01; op_alu = OPALU_W'(ALU_ADD); end
                OP_MOVE:   begin reg_dst = 1'b1; orig_alu = 2'b11; op_alu = OPALU_W'(ALU_ADD); end
                OP_JAL:    begin orig_alu = 2'b10; sel_extensor = 2'b10; op_alu = OPALU_W'(ALU_JAL); end
                OP_JUMP:   begin sel_extensor = 2'b10; end
                OP_SLT:    begin reg_dst = 1'b1; op_alu = OPALU_W'(ALU_SLT); end
                OP_BEQ:    begin op_alu = OPALU_W'(ALU_BEQ); end
                OP_BGT:    begin op_alu = OPALU_W'(ALU_BGT); end
                OP_BLET:   begin op_alu = OPALU_W'(ALU_BLET); end
                OP_LOADR:  begin memtoreg = 1'b1; op_alu = OPALU_W'(ALU_ADD); end
                OP_STOREI: begin orig_alu = 2'b01; sel_extensor = 2'b01; op_alu = OPALU_W'(ALU_ADD); end
                OP_STORER: begin op_alu = OPALU_W'(ALU_ADD); end
                default:   begin end
            endcase
        end
    end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multi-cycle Moore control unit: fetch, decode, execute (variable latency
// for mul/div), memory, I/O handshake wait, write-back and a sticky halt.
module unidade_controle_multiciclo import controle_pkg::*; #(
    parameter int OPCODE_W   = 6,
    parameter int OPALU_W    = 4,
    parameter int MUL_CICLOS = 4,
    parameter int DIV_CICLOS = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    unidade_controle_multiciclo_if.master bus
);

    localparam int MAX_CICLOS = (MUL_CICLOS > DIV_CICLOS) ? MUL_CICLOS : DIV_CICLOS;
    localparam int CW         = $clog2(MAX_CICLOS + 1);

    estado_t             estado_reg, estado_next;
    logic [OPCODE_W-1:0] opcode_r, opcode_next;
    logic [CW-1:0]       contador, contador_next;

    logic [OPCODE_W-1:0] opcode_dec;
    logic [4:0]          op;
    logic                dec_reg_dst, dec_memtoreg, dec_enable, dec_valido;
    logic [1:0]          dec_orig_alu, dec_sel_extensor;
    logic [OPALU_W-1:0]  dec_op_alu;
    int                  ciclos_exec;
    logic                ultimo;

    // The live opcode is only looked at while decoding; every other state
    // works from the latched copy so the fields stay stable.
    assign opcode_dec = (estado_reg == DECODIFICA) ? bus.OPCODE : opcode_r;
    assign op         = opcode_dec[4:0];

    decodificador_campos #(
        .OPCODE_W (OPCODE_W),
        .OPALU_W  (OPALU_W)
    ) u_decodificador (
        .opcode       (opcode_dec),
        .reg_dst      (dec_reg_dst),
        .memtoreg     (dec_memtoreg),
        .orig_alu     (dec_orig_alu),
        .sel_extensor (dec_sel_extensor),
        .op_alu       (dec_op_alu),
        .enable       (dec_enable),
        .valido       (dec_valido)
    );

    // Execute-phase length and last-cycle detection.
    always_comb begin
        ciclos_exec = 1;
        if (op == OP_MUL)      ciclos_exec = MUL_CICLOS;
        else if (op == OP_DIV) ciclos_exec = DIV_CICLOS;
        ultimo = (contador == CW'(ciclos_exec - 1));
    end

    // State, latched opcode and execute counter; reset aborts immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_reg <= INICIO;
            opcode_r   <= '0;
            contador   <= '0;
        end else begin
            estado_reg <= estado_next;
            opcode_r   <= opcode_next;
            contador   <= contador_next;
        end
    end

    // Next-state logic. The counter is held at zero outside EXECUTA so it
    // is already cleared on entry.
    always_comb begin
        estado_next   = estado_reg;
        opcode_next   = opcode_r;
        contador_next = '0;
        case (estado_reg)
            INICIO:     estado_next = BUSCA;
            BUSCA:      estado_next = DECODIFICA;
            DECODIFICA: begin
                opcode_next = bus.OPCODE;
                if (!dec_valido)                      estado_next = BUSCA;
                else if (op == OP_NOP)                estado_next = BUSCA;
                else if (op == OP_HLT)                estado_next = PARADO;
                else if (op == OP_IN || op == OP_OUT) estado_next = ESPERA_IO;
                else                                  estado_next = EXECUTA;
            end
            EXECUTA: begin
                if (!ultimo)                                         contador_next = contador + 1'b1;
                else if (eh_desvio(op) || op == OP_JUMP || op == OP_JR) estado_next = BUSCA;
                else if (eh_load(op) || eh_store(op))                estado_next = MEMORIA;
                else                                                 estado_next = ESCRITA;
            end
            MEMORIA:    estado_next = eh_store(op) ? BUSCA : ESCRITA;
            ESPERA_IO: begin
                if (op == OP_IN && bus.entrada_valida)     estado_next = ESCRITA;
                else if (op == OP_OUT && bus.saida_pronta) estado_next = BUSCA;
            end
            ESCRITA:    estado_next = BUSCA;
            PARADO:     estado_next = PARADO;
            default:    estado_next = INICIO;
        endcase
    end

    // Moore outputs: static fields while the instruction is in flight, plus
    // per-state strobes. opcode_invalido is the one exception, flagged in the
    // same decode cycle from the opcode being decoded.
    always_comb begin
        bus.EscrevePC       = 1'b0;
        bus.EscreveIR       = 1'b0;
        bus.RegDst          = 1'b0;
        bus.Memtoreg        = 1'b0;
        bus.OrigALU         = 2'b00;
        bus.selExtensor     = 2'b00;
        bus.OpALU           = '0;
        bus.Branch          = 1'b0;
        bus.Jump            = 1'b0;
        bus.Jr              = 1'b0;
        bus.EscreveMem      = 1'b0;
        bus.EscreveReg      = 1'b0;
        bus.Enable          = 1'b0;
        bus.in              = 1'b0;
        bus.out             = 1'b0;
        bus.hlt             = 1'b0;
        bus.opcode_invalido = 1'b0;
        if (estado_reg == EXECUTA || estado_reg == MEMORIA ||
            estado_reg == ESPERA_IO || estado_reg == ESCRITA) begin
            bus.RegDst      = dec_reg_dst;
            bus.Memtoreg    = dec_memtoreg;
            bus.OrigALU     = dec_orig_alu;
            bus.selExtensor = dec_sel_extensor;
            bus.OpALU       = dec_op_alu;
            bus.Enable      = dec_enable;
        end
        case (estado_reg)
            BUSCA: begin
                bus.EscreveIR = 1'b1;
                bus.EscrevePC = 1'b1;
            end
            DECODIFICA: bus.opcode_invalido = !dec_valido;
            EXECUTA: begin
                if (ultimo) begin
                    bus.Branch = eh_desvio(op);
                    bus.Jump   = (op == OP_JUMP) || (op == OP_JAL);
                    bus.Jr     = (op == OP_JR) || (op == OP_JAL);
                end
            end
            MEMORIA:   bus.EscreveMem = eh_store(op);
            ESPERA_IO: begin
                bus.in  = (op == OP_IN);
                bus.out = (op == OP_OUT);
            end
            ESCRITA:   bus.EscreveReg = 1'b1;
            PARADO:    bus.hlt = 1'b1;
            default:   begin end
        endcase
    end

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Self-checking bench for the multi-cycle control unit: a table of single
// instructions with hand-computed strobe timing, plus hand-written
// sequences for reset abort, I/O handshakes and halt.
module tb_unidade_controle_multiciclo;

    logic clock;
    logic reset;
    int   testes;
    int   falhas;

    unidade_controle_multiciclo_if #(.OPCODE_W(6), .OPALU_W(4)) bus ();

    unidade_controle_multiciclo #(
        .OPCODE_W   (6),
        .OPALU_W    (4),
        .MUL_CICLOS (4),
        .DIV_CICLOS (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Bit c of each mask = strobe high in cycle c, cycle 1 being BUSCA.
    typedef struct {
        logic [5:0]  op;
        int          len;
        logic [31:0] reg_m;
        logic [31:0] mem_m;
        logic [31:0] br_m;
        logic [31:0] j_m;
        logic [31:0] jr_m;
        logic [31:0] inv_m;
        logic [31:0] m2r_m;   // only cycles 4-5 compared
        bit          campos;
        logic [3:0]  opalu;
        logic        regdst;
        logic [1:0]  origalu;
    } vetor_t;

    localparam int NV = 21;
    vetor_t vetores[NV];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic verifica(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        testes++;
        if (atual !== esperado) begin
            falhas++;
            $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
        end
    endtask

    function automatic logic [31:0] saidas();
        return 32'({bus.EscrevePC, bus.EscreveIR, bus.RegDst, bus.Memtoreg,
                    bus.OrigALU, bus.selExtensor, bus.OpALU, bus.Branch,
                    bus.Jump, bus.Jr, bus.EscreveMem, bus.EscreveReg,
                    bus.Enable, bus.in, bus.out, bus.hlt, bus.opcode_invalido});
    endfunction

    // Runs one instruction starting in BUSCA, ending in the next BUSCA.
    task automatic executa(input vetor_t v);
        int c;
        logic [31:0] m_reg, m_mem, m_br, m_j, m_jr, m_inv, m_m2r, m_pc;
        logic [3:0] opalu3;
        logic rd3;
        logic [1:0] oa3;
        m_reg = 0; m_mem = 0; m_br = 0; m_j = 0; m_jr = 0; m_inv = 0; m_m2r = 0; m_pc = 0;
        opalu3 = 0; rd3 = 0; oa3 = 0;
        bus.OPCODE = v.op;
        c = 1;
        do begin
            if (c < 32) begin
                m_reg |= 32'(bus.EscreveReg) << c;
                m_mem |= 32'(bus.EscreveMem) << c;
                m_br  |= 32'(bus.Branch) << c;
                m_j   |= 32'(bus.Jump) << c;
                m_jr  |= 32'(bus.Jr) << c;
                m_inv |= 32'(bus.opcode_invalido) << c;
                m_m2r |= 32'(bus.Memtoreg) << c;
                m_pc  |= 32'(bus.EscrevePC) << c;
            end
            if (c == 3) begin
                opalu3 = bus.OpALU;
                rd3    = bus.RegDst;
                oa3    = bus.OrigALU;
            end
            tick();
            c++;
        end while (!bus.EscreveIR && c < 64);
        verifica($sformatf("op%0d_len", v.op), 32'(c - 1), 32'(v.len));
        verifica($sformatf("op%0d_escrevereg", v.op), m_reg, v.reg_m);
        verifica($sformatf("op%0d_escrevemem", v.op), m_mem, v.mem_m);
        verifica($sformatf("op%0d_branch", v.op), m_br, v.br_m);
        verifica($sformatf("op%0d_jump", v.op), m_j, v.j_m);
        verifica($sformatf("op%0d_jr", v.op), m_jr, v.jr_m);
        verifica($sformatf("op%0d_invalido", v.op), m_inv, v.inv_m);
        verifica($sformatf("op%0d_memtoreg", v.op), m_m2r & 32'h30, v.m2r_m);
        verifica($sformatf("op%0d_escrevepc", v.op), m_pc, 32'h2);
        if (v.campos) begin
            verifica($sformatf("op%0d_opalu", v.op), 32'(opalu3), 32'(v.opalu));
            verifica($sformatf("op%0d_regdst", v.op), 32'(rd3), 32'(v.regdst));
            verifica($sformatf("op%0d_origalu", v.op), 32'(oa3), 32'(v.origalu));
        end
        $display("[TB] op=%0d cycles=%0d reg=%0h mem=%0h br=%0h j=%0h jr=%0h inv=%0h opalu=%0b",
                 v.op, c - 1, m_reg, m_mem, m_br, m_j, m_jr, m_inv, opalu3);
    endtask

    initial begin
        int n;
        logic viu_reg;
        testes = 0;
        falhas = 0;

        //            op     len reg      mem      br      j       jr      inv     m2r      campos opalu   rd  oa
        vetores[0]  = '{6'd0,  4, 32'h10,  32'h0,  32'h0,  32'h0,  32'h0,  32'h0,  32'h0,  1'b1, 4'b0000, 1'b1, 2'b00};
        vetores[1]  = '{6'd1,  4, 32'h10,  32'h0,  32'h0,  32'h0,  32'h0,  32'h0,  32'h0,  1'b1, 4'b0001, 1'b1, 2'b00};
        vetores[2]  = '{6'd2,  7, 32'h80,  32'h0,  32'h0,  32'h0,  32'h0,  32'h0,  32'h0,  1'b1, 4'b0010, 1'b1, 2'b00};
        vetores[3]  = '{6'd3, 11, 32'h800, 32'h0,  32'h0,  32'h0,  32'h0,  32'h0,  32'h0,  1'b1, 4'b0011, 1'b1, 2'b00};
        vetores[4]  = '{6'd4,  4, 32'h10,  32'h0,  32'h0,  32'h0,  32'h0,  32'h0,  32'h0,  1'b1, 4'b0000, 1'b0, 2'b01};
        vetores[5]  = '{6'd6,  4, 32'h10,  32'h0,  32'h0,  32'h0,  32'h0,  32'h0,  32'h0,  1'b1, 4'b0101, 1'b1, 2'b00};
        vetores[6]  = '{6'd7,  4, 32'h10,  32'h0,  32'h0,  32'h0,  32'h0,  32'h0,  32'h0,  1'b1, 4'b0110, 1'b1, 2'b00};
        vetores[7]  = '{6'd8,  4, 32'h10,  32'h0,  32'h0,  32'h0,  32'h0,  32'h0,  32'h0,  1'b1, 4'b0100, 1'b1, 2'b00};
        vetores[8]  = '{6'd20, 4, 32'h10,  32'h0,  32'h0,  32'h0,  32'h0,  32'h0,  32'h0,  1'b1, 4'b1010, 1'b1, 2'b00};
        vetores[9]  = '{6'd10, 4, 32'h0,   32'h10, 32'h0,  32'h0,  32'h0,  32'h0,  32'h0,  1'b1, 4'b0000, 1'b0, 2'b01};
        vetores[10] = '{6'd9,  5, 32'h20,  32'h0,  32'h0,  32'h0,  32'h0,  32'h0,  32'h30, 1'b1, 4'b0000, 1'b0, 2'b01};
        vetores[11] = '{6'd25, 4, 32'h0,   32'h10, 32'h0,  32'h0,  32'h0,  32'h0,  32'h0,  1'b1, 4'b0000, 1'b0, 2'b01};
        vetores[12] = '{6'd24, 5, 32'h20,  32'h0,  32'h0,  32'h0,  32'h0,  32'h0,  32'h30, 1'b1, 4'b0000, 1'b0, 2'b00};
        vetores[13] = '{6'd21, 3, 32'h0,   32'h0,  32'h8,  32'h0,  32'h0,  32'h0,  32'h0,  1'b1, 4'b0111, 1'b0, 2'b00};
        vetores[14] = '{6'd22, 3, 32'h0,   32'h0,  32'h8,  32'h0,  32'h0,  32'h0,  32'h0,  1'b1, 4'b1000, 1'b0, 2'b00};
        vetores[15] = '{6'd19, 3, 32'h0,   32'h0,  32'h0,  32'h8,  32'h0,  32'h0,  32'h0,  1'b1, 4'b0000, 1'b0, 2'b00};
        vetores[16] = '{6'd17, 3, 32'h0,   32'h0,  32'h0,  32'h0,  32'h8,  32'h0,  32'h0,  1'b1, 4'b0000, 1'b0, 2'b00};
        vetores[17] = '{6'd18, 4, 32'h10,  32'h0,  32'h0,  32'h8,  32'h8,  32'h0,  32'h0,  1'b1, 4'b1011, 1'b0, 2'b10};
        vetores[18] = '{6'd13, 2, 32'h0,   32'h0,  32'h0,  32'h0,  32'h0,  32'h0,  32'h0,  1'b0, 4'b0000, 1'b0, 2'b00};
        vetores[19] = '{6'h3F, 2, 32'h0,   32'h0,  32'h0,  32'h0,  32'h0,  32'h4,  32'h0,  1'b0, 4'b0000, 1'b0, 2'b00};
        vetores[20] = '{6'h1B, 2, 32'h0,   32'h0,  32'h0,  32'h0,  32'h0,  32'h4,  32'h0,  1'b0, 4'b0000, 1'b0, 2'b00};

        reset = 1'b1;
        bus.OPCODE = '0;
        bus.entrada_valida = 1'b0;
        bus.saida_pronta = 1'b0;
        #1;
        verifica("reset_saidas", saidas(), 32'h0);
        repeat (3) tick();
        verifica("reset_mantido", saidas(), 32'h0);
        reset = 1'b0;
        verifica("inicio_saidas", saidas(), 32'h0);
        tick();
        verifica("busca_apos_inicio", 32'(bus.EscreveIR), 32'h1);

        for (int i = 0; i < NV; i++) executa(vetores[i]);

        // mul aborted by reset in its second execute cycle
        bus.OPCODE = 6'd2;
        tick();
        tick();
        verifica("mul_opalu_exec1", 32'(bus.OpALU), 32'h2);
        tick();
        verifica("mul_opalu_exec2", 32'(bus.OpALU), 32'h2);
        reset = 1'b1;
        #1;
        verifica("mul_reset_async", saidas(), 32'h0);
        viu_reg = 1'b0;
        repeat (6) begin
            tick();
            viu_reg |= bus.EscreveReg;
        end
        verifica("mul_reset_sem_escrevereg", 32'(viu_reg), 32'h0);
        reset = 1'b0;
        tick();
        verifica("mul_reset_volta_busca", 32'(bus.EscreveIR), 32'h1);
        $display("[TB] mul aborted by reset, reg_write_seen=%0b", viu_reg);

        // in with entrada_valida arriving after ten waiting cycles
        bus.OPCODE = 6'd15;
        tick();
        tick();
        n = 0;
        while (bus.in && n < 50) begin
            n++;
            if (n == 10) bus.entrada_valida = 1'b1;
            tick();
        end
        verifica("in_ciclos_espera", 32'(n), 32'd10);
        verifica("in_escrevereg", 32'(bus.EscreveReg), 32'h1);
        bus.entrada_valida = 1'b0;
        tick();
        verifica("in_volta_busca", 32'(bus.EscreveIR), 32'h1);
        $display("[TB] in waited %0d cycles", n);

        // out with saida_pronta already high
        bus.saida_pronta = 1'b1;
        bus.OPCODE = 6'd16;
        tick();
        tick();
        n = 0;
        while (bus.out && n < 50) begin
            n++;
            tick();
        end
        verifica("out_ciclos", 32'(n), 32'd1);
        verifica("out_volta_busca", 32'(bus.EscreveIR), 32'h1);
        bus.saida_pronta = 1'b0;
        $display("[TB] out held %0d cycles", n);

        // halt is absorbing regardless of opcode and handshake activity
        bus.OPCODE = 6'd14;
        tick();
        tick();
        for (int k = 0; k < 12; k++) begin
            verifica($sformatf("hlt_ciclo%0d", k), saidas(), 32'h2);
            bus.OPCODE = 6'($urandom);
            bus.entrada_valida = 1'($urandom);
            bus.saida_pronta = 1'($urandom);
            tick();
        end
        reset = 1'b1;
        #1;
        verifica("hlt_reset", saidas(), 32'h0);
        tick();
        reset = 1'b0;
        bus.entrada_valida = 1'b0;
        bus.saida_pronta = 1'b0;
        tick();
        verifica("hlt_reset_busca", 32'(bus.EscreveIR), 32'h1);
        $display("[TB] hlt sequence done");

        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end

endmodule
